// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake.
// Presents one bit pair per cycle (LSB first) to an external combinational
// full-adder stage and collects the sum bit and carry-out it returns.
// After WIDTH RUN cycles it holds {cout, sum} in DONE until the consumer
// accepts the result.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only has to index bits 0..WIDTH-1; it stops at the last bit
    // instead of wrapping, so no extra headroom bit is needed.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q,  op_a_d;
    logic [WIDTH-1:0] op_b_q,  op_b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;

    // State and datapath registers; reset takes effect without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and datapath update: latch on accept, one bit per RUN cycle.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    state_d = ST_RUN;
                    op_a_d  = op_a;
                    op_b_d  = op_b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Operands stay frozen; start_valid is not looked at here.
                sum_d[cnt_q] = fa_sum;
                carry_d      = fa_cout;
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    cout_d  = fa_cout;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                // A start request seen here is deliberately not accepted;
                // the controller must pass through IDLE first.
                if (done_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state; full-adder drive is zero outside RUN.
    always_comb begin
        start_ready = 1'b0;
        done_valid  = 1'b0;
        fa_a        = 1'b0;
        fa_b        = 1'b0;
        fa_cin      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
            end
            ST_RUN: begin
                fa_a   = op_a_q[cnt_q];
                fa_b   = op_b_q[cnt_q];
                fa_cin = carry_q;
            end
            ST_DONE: begin
                done_valid = 1'b1;
            end
            default: begin
                start_ready = 1'b0;
            end
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8) with a combinational full-adder model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] sum;
    logic         cout;

    int total;
    int bad;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .fa_a        (fa_a),
        .fa_b        (fa_b),
        .fa_cin      (fa_cin),
        .fa_sum      (fa_sum),
        .fa_cout     (fa_cout),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum         (sum),
        .cout        (cout)
    );

    // External full adder
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        int           hold;
        logic         jam;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".start_ready"}, {31'd0, start_ready}, 32'd1);
        chk({tag, ".done_valid"},  {31'd0, done_valid},  32'd0);
        chk({tag, ".sum"},         {24'd0, sum},         32'd0);
        chk({tag, ".cout"},        {31'd0, cout},        32'd0);
        chk({tag, ".fa"},          {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    endtask

    // Carry entering bit k, from plain integer addition of the low k bits.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input int k);
        int mask;
        int s;
        mask = (1 << k) - 1;
        s = (int'(a) & mask) + (int'(b) & mask) + int'(c);
        return ((s >> k) & 1) != 0;
    endfunction

    // One full operation; called #1 after a rising edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input int hold,
                          input logic jam);
        chk("pre.start_ready", {31'd0, start_ready}, 32'd1);
        start_valid = 1'b1;
        op_a = a;
        op_b = b;
        cin  = c;
        done_ready = 1'b1;
        tick(); // accepting edge
        if (jam) begin
            op_a = ~a;
            op_b = a ^ 8'h3C;
            cin  = ~c;
        end else begin
            start_valid = 1'b0;
            op_a = W'($urandom);
            op_b = W'($urandom);
            cin  = 1'($urandom);
        end
        for (int k = 0; k < W; k++) begin
            chk("run.start_ready", {31'd0, start_ready}, 32'd0);
            chk("run.done_valid",  {31'd0, done_valid},  32'd0);
            chk("run.fa_a",   {31'd0, fa_a},   {31'd0, a[k]});
            chk("run.fa_b",   {31'd0, fa_b},   {31'd0, b[k]});
            chk("run.fa_cin", {31'd0, fa_cin}, {31'd0, carry_into(a, b, c, k)});
            tick();
        end
        // WIDTH+1 edges counting the accepting edge
        chk("done.valid", {31'd0, done_valid}, 32'd1);
        chk("done.sum",   {24'd0, sum},        {24'd0, es});
        chk("done.cout",  {31'd0, cout},       {31'd0, ec});
        chk("done.fa",    {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        if (hold > 0) begin
            done_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("hold.valid",       {31'd0, done_valid},  32'd1);
                chk("hold.start_ready", {31'd0, start_ready}, 32'd0);
                chk("hold.sum",         {24'd0, sum},         {24'd0, es});
                chk("hold.cout",        {31'd0, cout},        {31'd0, ec});
            end
            done_ready = 1'b1;
        end
        tick(); // completing edge, start_valid may still be high if jammed
        chk("post.start_ready", {31'd0, start_ready}, 32'd1);
        chk("post.done_valid",  {31'd0, done_valid},  32'd0);
        start_valid = 1'b0;
        done_ready  = 1'b0;
        tick(); // mandatory idle cycle
    endtask

    initial begin
        logic [W:0] ref_full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        int dv_seen;

        total = 0;
        bad   = 0;
        rst = 1'b1;
        start_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        cin  = 1'b0;
        done_ready = 1'b0;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, c: 1'b0, exp_sum: 8'h96, exp_cout: 1'b0, hold: 0, jam: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1, hold: 0, jam: 1'b0};
        vecs[2] = '{a: 8'hFF, b: 8'h00, c: 1'b1, exp_sum: 8'h00, exp_cout: 1'b1, hold: 1, jam: 1'b0};
        vecs[3] = '{a: 8'h12, b: 8'h34, c: 1'b0, exp_sum: 8'h46, exp_cout: 1'b0, hold: 5, jam: 1'b1};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, exp_sum: 8'hFF, exp_cout: 1'b1, hold: 0, jam: 1'b1};
        vecs[5] = '{a: 8'h80, b: 8'h80, c: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1, hold: 2, jam: 1'b0};
        vecs[6] = '{a: 8'hAA, b: 8'h55, c: 1'b0, exp_sum: 8'hFF, exp_cout: 1'b0, hold: 0, jam: 1'b0};
        vecs[7] = '{a: 8'h00, b: 8'h00, c: 1'b0, exp_sum: 8'h00, exp_cout: 1'b0, hold: 0, jam: 1'b1};

        #2;
        chk_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs("reset.clocked");
        rst = 1'b0;

        // Directed table, first start on the first edge after release
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_sum, vecs[i].exp_cout,
                   vecs[i].hold, vecs[i].jam);
        end

        // Reset pulse while bit 3 is being processed
        start_valid = 1'b1;
        op_a = 8'hC3;
        op_b = 8'h5E;
        cin  = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("midrun.fa_a", {31'd0, fa_a}, 32'd0); // bit 3 of 0xC3 is 0
        chk("midrun.fa_b", {31'd0, fa_b}, 32'd1); // bit 3 of 0x5E is 1
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrun.rst");
        tick();
        rst = 1'b0;
        dv_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done_valid) dv_seen++;
        end
        chk("midrun.no_done", dv_seen, 32'd0);
        chk_reset_outputs("midrun.after");
        run_op(8'hC3, 8'h5E, 1'b1, 8'h22, 1'b1, 0, 1'b0);

        // Reset while in DONE, then immediate restart after release
        start_valid = 1'b1;
        op_a = 8'h01;
        op_b = 8'h02;
        cin  = 1'b0;
        done_ready = 1'b0;
        tick();
        start_valid = 1'b0;
        for (int k = 0; k < W; k++) tick();
        chk("done2.valid", {31'd0, done_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("done.rst");
        tick();
        rst = 1'b0;
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, 1'b0);

        // Randomized operations checked against integer addition
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, ref_full[W-1:0], ref_full[W],
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (SHALL be >= 2).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start_valid  input  1  operand request valid.
REQ-005 start_ready  output  1  controller can accept a request.
REQ-006 op_a  input  WIDTH  addend A, sampled on start handshake.
REQ-007 op_b  input  WIDTH  addend B, sampled on start handshake.
REQ-008 cin  input  1  initial carry, sampled on start handshake.
REQ-009 fa_a  output  1  bit of A driven to the external full-adder stage.
REQ-010 fa_b  output  1  bit of B driven to the full-adder stage.
REQ-011 fa_cin  output  1  carry driven to the full-adder stage.
REQ-012 fa_sum  input  1  full-adder sum, combinational response to fa_a/fa_b/fa_cin.
REQ-013 fa_cout  input  1  full-adder carry-out, combinational response.
REQ-014 done_valid  output  1  result valid.
REQ-015 done_ready  input  1  consumer accepts result.
REQ-016 sum  output  WIDTH  registered result.
REQ-017 cout  output  1  registered final carry.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-019 IDLE: start_ready=1; start_valid=1 SHALL latch op_a, op_b, cin, clear bit counter and sum, enter RUN.
REQ-020 RUN: start_ready=0; start_valid SHALL be ignored and operands held.
REQ-021 RUN bit k (k=0..WIDTH-1, LSB first): fa_a=op_a[k], fa_b=op_b[k], fa_cin=carry register (cin for k=0).
REQ-022 Each RUN cycle SHALL write fa_sum into sum[k] and fa_cout into the carry register, then increment k.
REQ-023 RUN SHALL last exactly WIDTH cycles; after bit WIDTH-1 the FSM SHALL enter DONE with cout = last fa_cout.
REQ-024 Latency: done_valid SHALL rise WIDTH+1 clock edges after the accepting start edge.
REQ-025 DONE: done_valid=1, sum/cout stable; done_ready=1 SHALL return to IDLE on that edge.
REQ-026 DONE with done_ready=0 SHALL hold indefinitely with sum/cout unchanged.
REQ-027 done_ready in IDLE or RUN SHALL have no effect.
REQ-028 start_valid in the DONE cycle that completes handshake SHALL NOT be accepted; acceptance needs IDLE (one idle cycle minimum between operations).
REQ-029 Outside RUN, fa_a, fa_b, fa_cin SHALL drive 0.
REQ-030 Bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.
REQ-031 sum/cout SHALL equal op_a + op_b + cin modulo 2^(WIDTH+1) split as {cout,sum}.

Reset
REQ-032 rst=1 SHALL force IDLE immediately, independent of clk.
REQ-033 Reset values: start_ready=1, done_valid=0, sum=0, cout=0, fa_a=fa_b=fa_cin=0, carry and counter 0.
REQ-034 Reset during RUN or DONE SHALL discard the operation; no done_valid after release.
REQ-035 First start acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification (WIDTH=8, bench models full adder combinationally)
REQ-036 op_a=0x5A, op_b=0x3C, cin=0 -> done_valid 9 edges after accept, sum=0x96, cout=0.
REQ-037 op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1; fa_cin=1 on bits 1..7.
REQ-038 op_a=0xFF, op_b=0x00, cin=1 -> sum=0x00, cout=1; fa_cin=1 on bit 0.
REQ-039 done_ready=0 for 5 cycles in DONE -> done_valid stays 1, sum/cout unchanged; new start_valid ignored until IDLE.
REQ-040 start_valid held high during RUN with different operands -> result reflects first operands only.
REQ-041 rst pulse mid-RUN (bit 3) -> outputs at reset values immediately, no done_valid, next operation correct.
